// File: rtl/wb_fwd_ctl_if.sv
// Decode/execute/writeback signal bundle for the writeback-forwarding controller.
// The master side is the pipeline (decode, ALU, LSU, register file); the slave side is wb_fwd_ctl.
interface wb_fwd_ctl_if #(
  parameter int LEN_REG   = 32,
  parameter int LEN_REGNO = 5,
  parameter int NUM_SRC   = 2
);

  logic                         issue_valid;
  logic                         issue_we;
  logic                         issue_is_ld;
  logic [LEN_REGNO-1:0]         issue_rd;
  logic [NUM_SRC-1:0]           src_used;
  logic [NUM_SRC*LEN_REGNO-1:0] src_regno;
  logic [NUM_SRC*LEN_REG-1:0]   rf_data;
  logic [LEN_REG-1:0]           alu_result;
  logic [LEN_REG-1:0]           ld_result;

  logic [NUM_SRC*LEN_REG-1:0]   src_data;
  logic                         stall_o;
  logic                         issue_fire;
  logic                         wb_we;
  logic [LEN_REGNO-1:0]         wb_regno;
  logic [LEN_REG-1:0]           wb_data;

  modport master (
    output issue_valid, issue_we, issue_is_ld, issue_rd,
    output src_used, src_regno, rf_data, alu_result, ld_result,
    input  src_data, stall_o, issue_fire, wb_we, wb_regno, wb_data
  );

  modport slave (
    input  issue_valid, issue_we, issue_is_ld, issue_rd,
    input  src_used, src_regno, rf_data, alu_result, ld_result,
    output src_data, stall_o, issue_fire, wb_we, wb_regno, wb_data
  );

endinterface

// File: rtl/wb_fwd_ctl.sv
// Writeback forwarding and load-use interlock: tracks DEPTH stages of in-flight
// register writes, forwards live results to NUM_SRC operand ports and retires writes in order.
module wb_fwd_ctl #(
  parameter int LEN_REG   = 32,
  parameter int LEN_REGNO = 5,
  parameter int DEPTH     = 3,
  parameter int LD_LAT    = 2,
  parameter int NUM_SRC   = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic        clk,
  input  logic        rst,
  wb_fwd_ctl_if.slave bus
);

  localparam int LD_STG = LD_LAT - 1;

  logic               stall;
  logic               fire;
  logic               new_v;
  logic [NUM_SRC-1:0] blocked;

  // Writes to the hardwired zero register never enter the tracker.
  assign new_v = fire && bus.issue_we && !((ZERO_REG != 0) && (bus.issue_rd == '0));

  // ---------------------------------------------------------------------------
  // In-flight write stages. Everything shifts every cycle, stalled or not.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stg
    logic                 v_reg;
    logic                 ld_reg;
    logic                 rdy_reg;
    logic [LEN_REGNO-1:0] regno_reg;
    logic [LEN_REG-1:0]   data_reg;

    logic                 v_next;
    logic                 ld_next;
    logic                 rdy_next;
    logic [LEN_REGNO-1:0] regno_next;
    logic [LEN_REG-1:0]   data_next;

    logic                 live;
    logic [LEN_REG-1:0]   live_data;

    // Unready entries only have data in the cycle their producer presents it.
    always_comb begin
      live      = 1'b0;
      live_data = '0;
      if (v_reg && rdy_reg) begin
        live      = 1'b1;
        live_data = data_reg;
      end else if (v_reg && !ld_reg && (gi == 0)) begin
        live      = 1'b1;
        live_data = bus.alu_result;
      end else if (v_reg && ld_reg && (gi == LD_STG)) begin
        live      = 1'b1;
        live_data = bus.ld_result;
      end
    end

    if (gi == 0) begin : g_head
      always_comb begin
        v_next     = new_v;
        ld_next    = bus.issue_is_ld;
        regno_next = bus.issue_rd;
        rdy_next   = 1'b0;
        data_next  = '0;
      end
    end else begin : g_body
      // Live data of the previous stage is exactly what gets captured on the shift.
      always_comb begin
        v_next     = g_stg[gi-1].v_reg;
        ld_next    = g_stg[gi-1].ld_reg;
        regno_next = g_stg[gi-1].regno_reg;
        rdy_next   = g_stg[gi-1].live;
        data_next  = g_stg[gi-1].live_data;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_reg     <= 1'b0;
        ld_reg    <= 1'b0;
        rdy_reg   <= 1'b0;
        regno_reg <= '0;
        data_reg  <= '0;
      end else begin
        v_reg     <= v_next;
        ld_reg    <= ld_next;
        rdy_reg   <= rdy_next;
        regno_reg <= regno_next;
        data_reg  <= data_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand resolution per read port.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_port
    logic [LEN_REGNO-1:0] rs;
    logic [LEN_REG-1:0]   rf_word;
    logic                 is_zero;
    logic                 blk;
    logic [LEN_REG-1:0]   res;

    assign rs      = bus.src_regno[gi*LEN_REGNO +: LEN_REGNO];
    assign rf_word = bus.rf_data[gi*LEN_REG +: LEN_REG];
    assign is_zero = (ZERO_REG != 0) && (rs == '0);

    // Chain from the oldest stage toward stage 0 so the youngest match wins.
    // The retiring stage stays in the chain, covering the same-cycle RF write.
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_scan
      logic               match;
      logic               hit;
      logic               hit_live;
      logic [LEN_REG-1:0] hit_data;

      assign match = g_stg[gj].v_reg && (g_stg[gj].regno_reg == rs);

      if (gj == DEPTH - 1) begin : g_last
        assign hit      = match;
        assign hit_live = match && g_stg[gj].live;
        assign hit_data = match ? g_stg[gj].live_data : '0;
      end else begin : g_chain
        assign hit      = match || g_scan[gj+1].hit;
        assign hit_live = match ? g_stg[gj].live      : g_scan[gj+1].hit_live;
        assign hit_data = match ? g_stg[gj].live_data : g_scan[gj+1].hit_data;
      end
    end

    always_comb begin
      blk = 1'b0;
      res = rf_word;
      if (is_zero) begin
        res = '0;
      end else if (g_scan[0].hit) begin
        if (g_scan[0].hit_live) begin
          res = g_scan[0].hit_data;
        end else begin
          blk = 1'b1;
        end
      end
    end

    assign blocked[gi]                             = blk;
    assign bus.src_data[gi*LEN_REG +: LEN_REG]     = res;
  end

  // ---------------------------------------------------------------------------
  // Issue control and retirement.
  // ---------------------------------------------------------------------------
  assign stall          = bus.issue_valid & (|(bus.src_used & blocked));
  assign fire           = bus.issue_valid & ~stall;
  assign bus.stall_o    = stall;
  assign bus.issue_fire = fire;

  assign bus.wb_we    = g_stg[DEPTH-1].v_reg;
  assign bus.wb_regno = g_stg[DEPTH-1].v_reg ? g_stg[DEPTH-1].regno_reg : '0;
  assign bus.wb_data  = g_stg[DEPTH-1].v_reg ? g_stg[DEPTH-1].data_reg  : '0;

endmodule

// File: tb/tb_wb_fwd_ctl.sv
// Randomised scoreboard bench for wb_fwd_ctl: a cycle-arithmetic model of in-flight
// writes predicts each cycle's outputs, a separate monitor compares on the falling edge.
module tb_wb_fwd_ctl;

  localparam int LR   = 32;
  localparam int LN   = 5;
  localparam int DP   = 3;
  localparam int LL   = 2;
  localparam int NS   = 2;
  localparam int ZR   = 1;
  localparam int NCYC = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_fwd_ctl_if #(.LEN_REG(LR), .LEN_REGNO(LN), .NUM_SRC(NS)) bus ();

  wb_fwd_ctl #(
    .LEN_REG(LR), .LEN_REGNO(LN), .DEPTH(DP), .LD_LAT(LL), .NUM_SRC(NS), .ZERO_REG(ZR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // An architectural write in flight: issued in cycle 'issue', value known once produced.
  typedef struct {
    int            issue;
    logic [LN-1:0] rd;
    bit            ld;
    logic [LR-1:0] val;
  } wr_t;

  typedef struct {
    int               cyc;
    bit               rst_cyc;
    logic             stall;
    logic             fire;
    logic [NS-1:0]    chk;
    logic [NS*LR-1:0] src;
    logic             wb;
    logic [LN-1:0]    wb_rd;
    logic [LR-1:0]    wb_val;
  } exp_t;

  wr_t  inflight[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic step(input int c);
    exp_t             e;
    wr_t              w;
    bit               in_rst;
    logic             v, we, ld;
    logic [LN-1:0]    rd, rs;
    logic [NS-1:0]    used, blk;
    logic [NS*LN-1:0] regs;
    logic [NS*LR-1:0] rf;
    logic [LR-1:0]    alu, ldr;
    int               j;
    bit               ready;

    // Reset windows: power-on, and twice while a forced load sits at stage 1.
    in_rst = (c < 3) || (c >= 400 && c < 402) || (c >= 1200 && c < 1202);
    rst    = in_rst ? 1'b0 : 1'b1;
    if (in_rst) inflight.delete();
    while (inflight.size() > 0 && inflight[0].issue + DP < c) void'(inflight.pop_front());

    alu = $urandom;
    ldr = $urandom;
    foreach (inflight[i]) begin
      if (!inflight[i].ld && inflight[i].issue == c - 1)  inflight[i].val = alu;
      if (inflight[i].ld  && inflight[i].issue == c - LL) inflight[i].val = ldr;
    end

    v    = ($urandom_range(99) < 85) && !in_rst;
    we   = $urandom_range(99) < 85;
    ld   = $urandom_range(99) < 30;
    rd   = LN'($urandom_range(7));
    used = NS'($urandom);
    for (int p = 0; p < NS; p++) begin
      regs[p*LN +: LN] = LN'($urandom_range(7));
      rf[p*LR +: LR]   = ($urandom_range(3) == 0) ? 32'h0000_FFFF : 32'($urandom);
    end
    if (c == 398 || c == 1198) begin
      v = 1'b1; we = 1'b1; ld = 1'b1; rd = LN'(3); used = '0;
    end

    bus.issue_valid = v;
    bus.issue_we    = we;
    bus.issue_is_ld = ld;
    bus.issue_rd    = rd;
    bus.src_used    = used;
    bus.src_regno   = regs;
    bus.rf_data     = rf;
    bus.alu_result  = alu;
    bus.ld_result   = ldr;

    e.cyc     = c;
    e.rst_cyc = in_rst;
    e.chk     = '0;
    e.src     = '0;
    blk       = '0;
    for (int p = 0; p < NS; p++) begin
      rs = regs[p*LN +: LN];
      if (ZR != 0 && rs == '0) begin
        e.chk[p] = 1'b1;
      end else begin
        j = -1;
        for (int k = inflight.size() - 1; k >= 0; k--) begin
          if (inflight[k].rd == rs) begin
            j = k;
            break;
          end
        end
        if (j < 0) begin
          e.src[p*LR +: LR] = rf[p*LR +: LR];
          e.chk[p]          = 1'b1;
        end else begin
          ready = inflight[j].ld ? (c >= inflight[j].issue + LL) : (c >= inflight[j].issue + 1);
          if (ready) begin
            e.src[p*LR +: LR] = inflight[j].val;
            e.chk[p]          = 1'b1;
          end else begin
            blk[p] = 1'b1;
          end
        end
      end
    end
    e.stall = v && |(used & blk);
    e.fire  = v && !e.stall;

    e.wb     = 1'b0;
    e.wb_rd  = '0;
    e.wb_val = '0;
    if (inflight.size() > 0 && inflight[0].issue + DP == c) begin
      e.wb     = 1'b1;
      e.wb_rd  = inflight[0].rd;
      e.wb_val = inflight[0].val;
    end
    exp_q.push_back(e);

    if (e.fire && we && !(ZR != 0 && rd == '0)) begin
      w.issue = c;
      w.rd    = rd;
      w.ld    = ld;
      w.val   = '0;
      inflight.push_back(w);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_o", e.cyc, 64'(bus.stall_o), 64'(e.stall));
        check("issue_fire", e.cyc, 64'(bus.issue_fire), 64'(e.fire));
        for (int p = 0; p < NS; p++) begin
          if (e.chk[p])
            check($sformatf("src_data[%0d]", p), e.cyc, 64'(bus.src_data[p*LR +: LR]), 64'(e.src[p*LR +: LR]));
        end
        check("wb_we", e.cyc, 64'(bus.wb_we), 64'(e.wb));
        if (e.wb) begin
          check("wb_regno", e.cyc, 64'(bus.wb_regno), 64'(e.wb_rd));
          check("wb_data", e.cyc, 64'(bus.wb_data), 64'(e.wb_val));
          $display("[TB] cyc %0d writeback r%0d = %08h", e.cyc, bus.wb_regno, bus.wb_data);
        end
        if (e.rst_cyc) begin
          check("rst_wb_regno", e.cyc, 64'(bus.wb_regno), 64'(0));
          check("rst_wb_data", e.cyc, 64'(bus.wb_data), 64'(0));
        end
      end
    end
  end

  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_is_ld = 1'b0;
    bus.issue_rd    = '0;
    bus.src_used    = '0;
    bus.src_regno   = '0;
    bus.rf_data     = '0;
    bus.alu_result  = '0;
    bus.ld_result   = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      step(c);
    end
    repeat (3) @(posedge clk);
    check("scoreboard_drained", NCYC, 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_fwd_ctl.md
# wb_fwd_ctl

Parametrised writeback-forwarding and load-use interlock controller for the pipelined core. It sits between decode and execute. It tracks every in-flight register write for `DEPTH` stages and captures ALU and load results as they appear. It supplies forwarded operands to `NUM_SRC` read ports, stalls issue when an operand is not ready yet, and retires writes to the register file. This generalises the single-path LD/ALU writeback select into an N-stage, N-port, variable-latency scheme.

## Interface
Parameters:
- `LEN_REG`, 32: register data width.
- `LEN_REGNO`, 5: register number width.
- `DEPTH`, 3: tracked in-flight stages. Legal range is 2..8.
- `LD_LAT`, 2: load latency in stages. Legal range is 1..DEPTH-1.
- `NUM_SRC`, 2: operand read ports. Legal range is 1..4.
- `ZERO_REG`, 1: when 1, register 0 is hardwired to zero. It is never tracked or forwarded.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `issue_valid`, in, 1: decode presents an instruction.
- `issue_we`, in, 1: the instruction writes `issue_rd`.
- `issue_is_ld`, in, 1: the instruction is a load.
- `issue_rd`, in, LEN_REGNO: destination register.
- `src_used`, in, NUM_SRC: per-port operand in use.
- `src_regno`, in, NUM_SRC*LEN_REGNO: source registers, packed with port 0 in the LSBs.
- `rf_data`, in, NUM_SRC*LEN_REG: register-file read data per port.
- `alu_result`, in, LEN_REG: result for the stage-0 ALU entry.
- `ld_result`, in, LEN_REG: result for the load entry at stage LD_LAT-1.
- `src_data`, out, NUM_SRC*LEN_REG: resolved operands.
- `stall_o`, out, 1: issue is blocked this cycle. Combinational.
- `issue_fire`, out, 1: equals `issue_valid & ~stall_o`.
- `wb_we`, out, 1: register-file write enable.
- `wb_regno`, out, LEN_REGNO: write-back register.
- `wb_data`, out, LEN_REG: write-back data.

## Operation
Entry state:
- Stages 0..DEPTH-1 each hold `{v, ld, regno, rdy, data}`.
- Every cycle, all entries shift one stage toward DEPTH-1. The shift happens unconditionally, including while stalled.
- Stage 0 loads a new entry on `issue_fire & issue_we`, provided `ZERO_REG` is 0 or `issue_rd` is not 0. It loads a bubble (`v=0`) otherwise.
- A new entry has `ld=issue_is_ld`, `rdy=0`.

Result capture at the clock edge:
- A stage-0 entry with `v & ~ld` latches `alu_result` and sets `rdy=1` as it moves to stage 1.
- A stage LD_LAT-1 entry with `v & ld` latches `ld_result` and sets `rdy=1`.

Live data for an entry: `data` if `rdy`. Otherwise `alu_result` for stage-0 ALU entries, or `ld_result` for loads at stage LD_LAT-1. Any other unready entry has no live data.

Operand resolution for each port p:
- The match is the youngest (lowest stage index) valid entry with `regno == src_regno[p]`.
- If there is no match, `src_data[p] = rf_data[p]`.
- If the port reads register 0 with `ZERO_REG=1`, `src_data[p] = 0`.
- If there is a match with live data, `src_data[p]` is that data.
- If there is a match without live data, port p is blocked.
- `stall_o = issue_valid & OR(src_used[p] & blocked[p])`.

Retirement:
- A valid entry at stage DEPTH-1 drives `wb_we=1`, `wb_regno=regno`, `wb_data=data`. `rdy` is guaranteed there because LD_LAT < DEPTH.
- That entry is also still matchable in its final cycle, so a same-cycle register-file write never produces a stale read.

Reset:
- All `v`, `rdy`, and `data` clear asynchronously.
- A reset mid-stream discards every in-flight write. No write-back occurs for discarded entries.

## Timing
- Issue at cycle t: the entry is at stage 0 in t+1 and stage k in t+1+k. It writes back in cycle t+DEPTH.
- ALU-to-dependent forwarding has zero bubbles. A load-use dependency stalls exactly LD_LAT-1 cycles.
- `stall_o`, `issue_fire`, and `src_data` are combinational from current-cycle inputs and state. `wb_*` depends only on registered state.
- Reset values: `stall_o=0`, `issue_fire=0`, `wb_we=0`, `wb_regno=0`, `wb_data=0`. `src_data` equals `rf_data`, or 0 for reg-0 ports.
- When multiple entries target the same register, the youngest wins on forwarding. Older entries still retire in program order.

## Test plan
- ALU chain: issue r1, then the next cycle issue r2=r1+x with `alu_result=0x10`. Expect no stall, `src_data[0]=0x10`, and r1 written back in cycle t+3.
- Load-use with LD_LAT=2: issue an ld to r3, then a dependent use of r3. Expect `stall_o=1` for 1 cycle. In the following cycle `ld_result=0xABCD` is forwarded to the dependent instruction and `issue_fire=1`.
- Unused operand: `src_used=0` while `src_regno` matches a pending load. Expect no stall.
- Double write: r5=1 at t and r5=2 at t+1, then a read of r5 at t+2. Expect 2, and write-backs of 1 then 2 in order.
- Reg 0 with ZERO_REG=1: a write to r0 creates no entry and `wb_we` stays 0. A read of r0 returns 0 even if `rf_data=0xFFFF`.
- Reset mid-load: drop `rst` low while a load is at stage 1. Expect `wb_we=0` afterwards, `stall_o=0`, and all entries invalid.
